// File: rtl/limbus_dbg_pkg.sv
// Shared types and constants for the Nios debug command transfer block.
// Default widths describe the classic 2-bit IR / 38-bit DR bridge.
package limbus_dbg_pkg;

    localparam int DBG_IR_W = 2;
    localparam int DBG_DR_W = 38;

    // The most significant DR bit selects take_action over take_no_action.
    function automatic int dbg_action_bit(input int dr_w);
        return dr_w - 1;
    endfunction

    localparam int DBG_ACTION_BIT = dbg_action_bit(DBG_DR_W);

    typedef struct packed {
        logic [DBG_IR_W-1:0] ir;
        logic [DBG_DR_W-1:0] dr;
    } dbg_cmd_t;

    typedef enum logic {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } out_state_e;

endpackage

// File: rtl/limbus_dbg_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// The detector only arms after a synchronised low, so a level already high at reset release is ignored.
module limbus_dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] vld_reg;
    logic                   edge_reg;
    logic                   armed_reg;

    // vld_reg tracks which synchroniser stages hold real samples rather than reset zeros.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b0;
                    vld_reg[gi]  <= 1'b0;
                end else if (gi == 0) begin
                    sync_reg[gi] <= async_in;
                    vld_reg[gi]  <= 1'b1;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                    vld_reg[gi]  <= vld_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            edge_reg <= sync_reg[SYNC_STAGES-1];
            if (vld_reg[SYNC_STAGES-1] && !sync_reg[SYNC_STAGES-1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~edge_reg & armed_reg;

endmodule

// File: rtl/limbus_nios_dbg_cmd_xfer.sv
// System-clock side of the Nios debug JTAG bridge: captures {ir,sr} on update-DR, queues and presents commands.
// Define LIMBUS_DBG_CMD_STATS_EN to add saturating accept/drop counters.
module limbus_nios_dbg_cmd_xfer
    import limbus_dbg_pkg::*;
#(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NUM_IR     = 2**IR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DR_W-1:0]   sr_i,
    input  logic [IR_W-1:0]   ir_in_i,
    input  logic              udr_i,
    input  logic              uir_i,
    input  logic              cmd_ready_i,
    input  logic              clr_ovf_i,
    output logic              cmd_valid_o,
    output logic [IR_W-1:0]   cmd_ir_o,
    output logic [DR_W-1:0]   jdo_o,
    output logic [NUM_IR-1:0] take_action_o,
    output logic [NUM_IR-1:0] take_no_action_o,
    output logic              ir_update_o,
    output logic              ovf_o
`ifdef LIMBUS_DBG_CMD_STATS_EN
    ,
    output logic [15:0]       acc_cnt_o,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int ACT_BIT = dbg_action_bit(DR_W);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
    } cmd_t;

    logic udr_ev;
    logic uir_ev;

    limbus_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (udr_i),
        .rise     (udr_ev)
    );

    limbus_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (uir_i),
        .rise     (uir_ev)
    );

    assign ir_update_o = uir_ev;

    cmd_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    out_state_e      state_reg;
    out_state_e      state_next;
    cmd_t            cmd_reg;
    logic [NUM_IR-1:0] take_action_reg;
    logic [NUM_IR-1:0] take_no_action_reg;
    logic            ovf_reg;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic drop;
    logic pop;
    logic accept;
    logic [NUM_IR-1:0] ir_onehot;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign push       = udr_ev & ~fifo_full;
    assign drop       = udr_ev & fifo_full;
    assign accept     = (state_reg == PRESENT) & cmd_ready_i;
    assign ir_onehot  = NUM_IR'(1) << cmd_reg.ir;

    // The output register doubles as the registered read port of the queue.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (cmd_ready_i) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= '{ir: ir_in_i, dr: sr_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= EMPTY;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            cmd_reg            <= '0;
            take_action_reg    <= '0;
            take_no_action_reg <= '0;
            ovf_reg            <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_reg + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                cmd_reg    <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            take_action_reg    <= '0;
            take_no_action_reg <= '0;
            if (accept) begin
                if (cmd_reg.dr[ACT_BIT]) begin
                    take_action_reg <= ir_onehot;
                end else begin
                    take_no_action_reg <= ir_onehot;
                end
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign cmd_valid_o      = (state_reg == PRESENT);
    assign cmd_ir_o         = cmd_reg.ir;
    assign jdo_o            = cmd_reg.dr;
    assign take_action_o    = take_action_reg;
    assign take_no_action_o = take_no_action_reg;
    assign ovf_o            = ovf_reg;

`ifdef LIMBUS_DBG_CMD_STATS_EN
    logic [15:0] acc_cnt_reg;
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clr_ovf_i) begin
            acc_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (accept && acc_cnt_reg != 16'hFFFF) begin
                acc_cnt_reg <= acc_cnt_reg + 16'd1;
            end
            if (drop && drop_cnt_reg != 16'hFFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign acc_cnt_o  = acc_cnt_reg;
    assign drop_cnt_o = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_limbus_nios_dbg_cmd_xfer.sv
// Directed bench for limbus_nios_dbg_cmd_xfer with default parameters (IR_W=2, DR_W=38, SYNC_STAGES=2, FIFO_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_limbus_nios_dbg_cmd_xfer;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] sr;
    logic [1:0]  ir_in;
    logic        udr;
    logic        uir;
    logic        ready;
    logic        clr;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        ir_update;
    logic        ovf;
`ifdef LIMBUS_DBG_CMD_STATS_EN
    logic [15:0] acc_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    limbus_nios_dbg_cmd_xfer dut (
        .clk              (clk),
        .reset            (reset),
        .sr_i             (sr),
        .ir_in_i          (ir_in),
        .udr_i            (udr),
        .uir_i            (uir),
        .cmd_ready_i      (ready),
        .clr_ovf_i        (clr),
        .cmd_valid_o      (cmd_valid),
        .cmd_ir_o         (cmd_ir),
        .jdo_o            (jdo),
        .take_action_o    (take_action),
        .take_no_action_o (take_no_action),
        .ir_update_o      (ir_update),
        .ovf_o            (ovf)
`ifdef LIMBUS_DBG_CMD_STATS_EN
        ,
        .acc_cnt_o        (acc_cnt),
        .drop_cnt_o       (drop_cnt)
`endif
    );

    // One update-DR transaction: 3 cycles high, 3 low, data held for the whole window.
    task automatic udr_event(input logic [1:0] ir_v, input logic [37:0] sr_v);
        ir_in = ir_v;
        sr    = sr_v;
        udr   = 1'b1;
        repeat (3) @(negedge clk);
        udr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; sr = '0; ir_in = '0; udr = 1'b0; uir = 1'b0; ready = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, ir_update, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b ir=%h jdo=%h ta=%b tn=%b iru=%b ovf=%b, expected all 0",
                     cmd_valid, cmd_ir, jdo, take_action, take_no_action, ir_update, ovf);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single();
        ready = 1'b1; ir_in = 2'd2; sr = 38'h20_0000_00AB; udr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++; $display("FAIL single_early_valid: got %b expected 0", cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || jdo !== 38'h20_0000_00AB || cmd_ir !== 2'd2) begin
            failures++;
            $display("FAIL single_present: got valid=%b jdo=%h ir=%0d expected valid=1 jdo=20000000ab ir=2",
                     cmd_valid, jdo, cmd_ir);
        end
        @(negedge clk);
        checks++;
        if (take_action !== 4'b0100 || take_no_action !== 4'b0000 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: got ta=%b tn=%b valid=%b expected ta=0100 tn=0000 valid=0",
                     take_action, take_no_action, cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (take_action !== 4'b0000) begin
            failures++; $display("FAIL single_pulse_width: got %b expected 0000", take_action);
        end
        udr = 1'b0;
        repeat (4) @(negedge clk);
        $display("test_single done");
    endtask

    task automatic test_ir_update();
        uir = 1'b1;
        @(negedge clk);
        checks++;
        if (ir_update !== 1'b0) begin
            failures++; $display("FAIL ir_update_early: got %b expected 0", ir_update);
        end
        @(negedge clk);
        checks++;
        if (ir_update !== 1'b1) begin
            failures++; $display("FAIL ir_update_pulse: got %b expected 1", ir_update);
        end
        @(negedge clk);
        checks++;
        if (ir_update !== 1'b0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL ir_update_width: got iru=%b valid=%b expected 0 0", ir_update, cmd_valid);
        end
        uir = 1'b0;
        repeat (4) @(negedge clk);
        $display("test_ir_update done");
    endtask

    task automatic test_no_action();
        ready = 1'b1; ir_in = 2'd1; sr = {1'b0, 37'h55}; udr = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (take_no_action !== 4'b0010 || take_action !== 4'b0000) begin
            failures++;
            $display("FAIL no_action_pulse: got ta=%b tn=%b expected ta=0000 tn=0010", take_action, take_no_action);
        end
        udr = 1'b0;
        repeat (4) @(negedge clk);
        $display("test_no_action done");
    endtask

    task automatic test_backpressure();
        logic [1:0]  exp_ir [6];
        logic [37:0] exp_sr [6];
        logic [3:0]  oh;
        logic [3:0]  exp_ta;
        logic [3:0]  exp_tn;
        for (int k = 0; k < 6; k++) begin
            exp_ir[k] = 2'(k);
            exp_sr[k] = {(k % 2 == 0) ? 1'b1 : 1'b0, 37'(4096 + k)};
        end
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            udr_event(exp_ir[k], exp_sr[k]);
            if (k == 1) begin
                checks++;
                if (cmd_valid !== 1'b1 || jdo !== exp_sr[0]) begin
                    failures++;
                    $display("FAIL bp_hold_early: got valid=%b jdo=%h expected valid=1 jdo=%h", cmd_valid, jdo, exp_sr[0]);
                end
            end
        end
        checks++;
        if (cmd_valid !== 1'b1 || jdo !== exp_sr[0] || cmd_ir !== exp_ir[0] || ovf !== 1'b1) begin
            failures++;
            $display("FAIL bp_full: got valid=%b jdo=%h ir=%0d ovf=%b expected valid=1 jdo=%h ir=%0d ovf=1",
                     cmd_valid, jdo, cmd_ir, ovf, exp_sr[0], exp_ir[0]);
        end
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            oh     = 4'b0001 << exp_ir[i];
            exp_ta = exp_sr[i][37] ? oh : 4'b0000;
            exp_tn = exp_sr[i][37] ? 4'b0000 : oh;
            checks++;
            if (take_action !== exp_ta || take_no_action !== exp_tn) begin
                failures++;
                $display("FAIL bp_accept_%0d: got ta=%b tn=%b expected ta=%b tn=%b", i, take_action, take_no_action, exp_ta, exp_tn);
            end
            checks++;
            if (i < 4) begin
                if (cmd_valid !== 1'b1 || jdo !== exp_sr[i+1] || cmd_ir !== exp_ir[i+1]) begin
                    failures++;
                    $display("FAIL bp_next_%0d: got valid=%b jdo=%h ir=%0d expected valid=1 jdo=%h ir=%0d",
                             i, cmd_valid, jdo, cmd_ir, exp_sr[i+1], exp_ir[i+1]);
                end
            end else if (cmd_valid !== 1'b0) begin
                failures++; $display("FAIL bp_drained: got valid=%b expected 0", cmd_valid);
            end
        end
        ready = 1'b0;
        @(negedge clk);
`ifdef LIMBUS_DBG_CMD_STATS_EN
        checks++;
        if (acc_cnt !== 16'd5 || drop_cnt !== 16'd1) begin
            failures++; $display("FAIL stats_counts: got acc=%0d drop=%0d expected acc=5 drop=1", acc_cnt, drop_cnt);
        end
`endif
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL bp_ovf_clear: got %b expected 0", ovf);
        end
`ifdef LIMBUS_DBG_CMD_STATS_EN
        checks++;
        if (acc_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            failures++; $display("FAIL stats_clear: got acc=%0d drop=%0d expected 0 0", acc_cnt, drop_cnt);
        end
`endif
        $display("test_backpressure done");
    endtask

    task automatic test_sticky_ovf();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            udr_event(2'(k), {1'b1, 37'(k)});
        end
        ir_in = 2'd3; sr = '0; udr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL sticky_before_drop: got %b expected 0", ovf);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            failures++; $display("FAIL sticky_set_wins: got %b expected 1", ovf);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL sticky_clear: got %b expected 0", ovf);
        end
        udr = 1'b0;
        repeat (3) @(negedge clk);
        $display("test_sticky_ovf done");
    endtask

    task automatic test_reset_mid();
        int bad_valid;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            udr_event(2'(k), {1'b0, 37'(k + 7)});
        end
        checks++;
        if (cmd_valid !== 1'b1) begin
            failures++; $display("FAIL mid_queued: got valid=%b expected 1", cmd_valid);
        end
        udr = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, ir_update, ovf} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got valid=%b ir=%h jdo=%h ta=%b tn=%b iru=%b ovf=%b, expected all 0",
                     cmd_valid, cmd_ir, jdo, take_action, take_no_action, ir_update, ovf);
        end
        ready = 1'b1;
        bad_valid = 0;
        repeat (8) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0 || take_action !== 4'b0 || take_no_action !== 4'b0) bad_valid++;
        end
        checks++;
        if (bad_valid != 0) begin
            failures++; $display("FAIL mid_high_udr_no_cmd: got %0d active cycles expected 0", bad_valid);
        end
        udr = 1'b0;
        repeat (4) @(negedge clk);
        ir_in = 2'd3; sr = {1'b1, 37'h3C}; udr = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || jdo !== {1'b1, 37'h3C}) begin
            failures++; $display("FAIL mid_fresh_edge: got valid=%b jdo=%h expected valid=1 jdo=%h", cmd_valid, jdo, {1'b1, 37'h3C});
        end
        @(negedge clk);
        checks++;
        if (take_action !== 4'b1000) begin
            failures++; $display("FAIL mid_fresh_pulse: got %b expected 1000", take_action);
        end
        udr = 1'b0; ready = 1'b0;
        repeat (3) @(negedge clk);
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_ir_update();
        test_no_action();
        test_backpressure();
        test_sticky_ovf();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
